calc_op_sequencer: RTL and testbench

Command sequencer for the 16-bit accumulator calculator datapath. It accepts (opcode, operand) commands through a valid/ready queue and issues each one to the datapath for exactly one clock, driving NO-OP (0000) at all other times. It captures the resulting 32-bit accumulator value and error flags, and returns them through a valid/ready response port. It sits between a host or test driver and the datapath's InputA/OpCode/Result/Error pins, replacing direct stimulus.

---
 rtl/calc_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Command sequencer for the 16-bit accumulator calculator datapath.
// Commands (opcode, operand) are queued in a small FIFO. Each one is issued
// to the datapath for exactly one clock, and NO-OP is driven at all other
// times. The resulting accumulator value and error flags are returned on a
// valid/ready response port.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   CmdValid/CmdReady     command handshake; CmdOp (4b), CmdData (16b)
//   Clear                 clears sticky errors; in HALT also flushes and resumes
//   DpInputA, DpOpCode    drive the datapath InputA / OpCode pins
//   DpResult, DpError     datapath accumulator value and error flags
//   ResValid/ResReady     response handshake; ResData (32b), ResOp, ResErr (3b)
//   ErrSticky             OR of all ResErr since the last Reset/Clear
//   Halted, Busy          status
//   DoneCount             completed responses, wraps at 8 bits
module calc_op_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [3:0]  CmdOp,
  input  logic [15:0] CmdData,
  input  logic        Clear,
  output logic [15:0] DpInputA,
  output logic [3:0]  DpOpCode,
  input  logic [31:0] DpResult,
  input  logic [1:0]  DpError,
  output logic        ResValid,
  input  logic        ResReady,
  output logic [31:0] ResData,
  output logic [3:0]  ResOp,
  output logic [2:0]  ResErr,
  output logic [2:0]  ErrSticky,
  output logic        Halted,
  output logic        Busy,
  output logic [7:0]  DoneCount
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    HALT
  } state_t;

  state_t      state;

  logic [3:0]  fifo_op   [FIFO_DEPTH];
  logic [15:0] fifo_data [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;

  logic [3:0]  op_reg;
  logic        illegal;
  logic [2:0]  err_reg;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign CmdReady = ~full & ~Halted;
  assign push     = CmdValid & CmdReady;
  assign Busy     = (state != IDLE) || !empty;

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]]   <= CmdOp;
      fifo_data[wr_ptr[AW-1:0]] <= CmdData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      op_reg    <= '0;
      illegal   <= 1'b0;
      err_reg   <= '0;
      DpOpCode  <= '0;
      DpInputA  <= '0;
      ResValid  <= 1'b0;
      ResData   <= '0;
      ResOp     <= '0;
      ResErr    <= '0;
      ErrSticky <= '0;
      DoneCount <= '0;
      Halted    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (Clear) ErrSticky <= '0;

      case (state)
        IDLE: begin
          // Datapath pins are registered, so they are loaded on the pop edge
          // to be valid throughout the ISSUE cycle.
          if (!empty) begin
            op_reg   <= fifo_op[rd_ptr[AW-1:0]];
            illegal  <= (fifo_op[rd_ptr[AW-1:0]] == 4'b0011);
            DpOpCode <= (fifo_op[rd_ptr[AW-1:0]] == 4'b0011) ?
                        4'b0000 : fifo_op[rd_ptr[AW-1:0]];
            DpInputA <= fifo_data[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          err_reg  <= {illegal, DpError};
          DpOpCode <= '0;
          DpInputA <= '0;
          state    <= CAPTURE;
        end

        CAPTURE: begin
          ResData   <= DpResult;
          ResOp     <= op_reg;
          ResErr    <= err_reg;
          ResValid  <= 1'b1;
          // A coincident Clear drops old errors but keeps this capture's.
          ErrSticky <= Clear ? err_reg : (ErrSticky | err_reg);
          DoneCount <= DoneCount + 8'd1;
          state     <= RESP;
        end

        RESP: begin
          if (ResReady) begin
            ResValid <= 1'b0;
            if (STOP_ON_ERR && (ResErr != 3'b000)) begin
              state  <= HALT;
              Halted <= 1'b1;
            end else begin
              state  <= IDLE;
            end
          end
        end

        HALT: begin
          // No push can occur while halted, so wr_ptr is stable here.
          if (Clear) begin
            rd_ptr <= wr_ptr;
            Halted <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: a small accumulator datapath stub, a
// command/response reference model, and directed scenarios with literal
// expectations.
module tb_calc_op_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [3:0]  CmdOp;
  logic [15:0] CmdData;
  logic        Clear;
  logic [15:0] DpInputA;
  logic [3:0]  DpOpCode;
  logic [31:0] DpResult;
  logic [1:0]  DpError;
  logic        ResValid;
  logic        ResReady;
  logic [31:0] ResData;
  logic [3:0]  ResOp;
  logic [2:0]  ResErr;
  logic [2:0]  ErrSticky;
  logic        Halted;
  logic        Busy;
  logic [7:0]  DoneCount;

  int checks = 0;
  int passes = 0;

  calc_op_sequencer #(.FIFO_DEPTH(4), .STOP_ON_ERR(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .Clear(Clear),
    .DpInputA(DpInputA), .DpOpCode(DpOpCode), .DpResult(DpResult),
    .DpError(DpError), .ResValid(ResValid), .ResReady(ResReady),
    .ResData(ResData), .ResOp(ResOp), .ResErr(ResErr),
    .ErrSticky(ErrSticky), .Halted(Halted), .Busy(Busy),
    .DoneCount(DoneCount)
  );

  always #5 Clk = ~Clk;

  // Datapath semantics: 0001 zero, 0100 add, 0101 sub (16-bit signed,
  // sign-extended result, overflow -> err[0]), 0110 multiply low halves,
  // 0111 operand divided by accumulator (zero accumulator -> err[1]).
  function automatic logic [33:0] dp_eval(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [31:0] cur);
    logic [15:0] s;
    logic [1:0]  e;
    logic [31:0] r;
    e = '0;
    r = cur;
    s = '0;
    case (op)
      4'b0001: r = '0;
      4'b0100: begin
        s = cur[15:0] + a;
        e[0] = (cur[15] == a[15]) && (s[15] != a[15]);
        r = {{16{s[15]}}, s};
      end
      4'b0101: begin
        s = cur[15:0] - a;
        e[0] = (cur[15] != a[15]) && (s[15] != cur[15]);
        r = {{16{s[15]}}, s};
      end
      4'b0110: r = {16'h0, cur[15:0]} * {16'h0, a};
      4'b0111: begin
        if (cur == 32'd0) e[1] = 1'b1;
        else r = {16'h0, a} / cur;
      end
      default: ;
    endcase
    return {e, r};
  endfunction

  logic [31:0] acc_dp = '0;
  logic [33:0] dp_out;
  always_comb dp_out = dp_eval(DpOpCode, DpInputA, acc_dp);
  assign DpResult = acc_dp;
  assign DpError  = dp_out[33:32];
  always @(posedge Clk) if (DpOpCode != 4'b0000) acc_dp <= dp_out[31:0];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
  endtask

  // Reference model: accepted commands in order, expected accumulator,
  // halt state and completed-response count.
  logic [19:0] cmd_q[$];
  logic [31:0] resp_data[$];
  logic [2:0]  resp_err[$];
  logic [3:0]  resp_op[$];
  logic [31:0] model_acc = '0;
  bit          acc_known = 1'b0;
  bit          model_halted = 1'b0;
  bit          model_on = 1'b0;
  logic [7:0]  resp_count = '0;
  logic [19:0] head;
  logic [3:0]  hop;
  logic [33:0] expv;
  logic [2:0]  exp_err;

  always @(negedge Clk) begin
    if (model_on && !Reset) begin
      check("no_op3_on_bus", 32'(DpOpCode == 4'b0011), 32'd0);
      check("halted", 32'(Halted), 32'(model_halted));
      if (model_halted) begin
        check("halt_no_issue", 32'(DpOpCode), 32'd0);
        check("halt_no_resp", 32'(ResValid), 32'd0);
      end else if (ResValid) begin
        if (cmd_q.size() == 0) begin
          check("stale_resp", 32'(ResValid), 32'd0);
        end else begin
          head    = cmd_q[0];
          hop     = head[19:16];
          expv    = dp_eval((hop == 4'b0011) ? 4'b0000 : hop, head[15:0], model_acc);
          exp_err = {hop == 4'b0011, expv[33:32]};
          check("res_op", 32'(ResOp), 32'(hop));
          check("res_err", 32'(ResErr), 32'(exp_err));
          if (acc_known || hop == 4'b0001) check("res_data", ResData, expv[31:0]);
          check("done_count", 32'(DoneCount), 32'(resp_count + 8'd1));
        end
      end
    end

    if (Reset) begin
      cmd_q.delete();
      model_halted = 1'b0;
      resp_count   = '0;
      acc_known    = 1'b0;
    end else if (model_on) begin
      if (Clear && model_halted) begin
        cmd_q.delete();
        model_halted = 1'b0;
      end
      if (ResValid && ResReady && cmd_q.size() > 0) begin
        head    = cmd_q.pop_front();
        hop     = head[19:16];
        expv    = dp_eval((hop == 4'b0011) ? 4'b0000 : hop, head[15:0], model_acc);
        exp_err = {hop == 4'b0011, expv[33:32]};
        model_acc  = expv[31:0];
        if (hop == 4'b0001) acc_known = 1'b1;
        resp_count = resp_count + 8'd1;
        if (exp_err != 3'b000) model_halted = 1'b1;
        resp_data.push_back(ResData);
        resp_err.push_back(ResErr);
        resp_op.push_back(ResOp);
      end
      if (CmdValid && CmdReady) cmd_q.push_back({CmdOp, CmdData});
    end
  end

  task automatic send(input logic [3:0] op, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk);
      ok = CmdReady;
      @(posedge Clk);
      #1;
    end
    CmdValid = 1'b0;
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 200 && resp_data.size() < target; i++) begin
      @(posedge Clk);
      #1;
    end
    check("resp_count", resp_data.size(), target);
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int base;
  int accepted;

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = '0; CmdData = '0;
    Clear = 1'b0; ResReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_on = 1'b1;

    check("rst_resvalid", 32'(ResValid), 32'd0);
    check("rst_donecount", 32'(DoneCount), 32'd0);
    check("rst_sticky", 32'(ErrSticky), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_cmdready", 32'(CmdReady), 32'd1);
    check("rst_dpop", 32'(DpOpCode), 32'd0);
    check("rst_resdata", ResData, 32'd0);

    // Basic sequence: zero, add 250, multiply by 150.
    base = resp_data.size();
    send(4'b0001, 16'd0);
    send(4'b0100, 16'd250);
    send(4'b0110, 16'd150);
    wait_resp(base + 3);
    check("t1_d0", resp_data[base], 32'h0000_0000);
    check("t1_d1", resp_data[base + 1], 32'h0000_00FA);
    check("t1_d2", resp_data[base + 2], 32'h0000_927C);
    check("t1_e2", 32'(resp_err[base + 2]), 32'd0);
    check("t1_done", 32'(DoneCount), 32'd3);

    // Add overflow halts; Clear resumes.
    base = resp_data.size();
    send(4'b0001, 16'd0);
    send(4'b0100, 16'h7FFF);
    send(4'b0100, 16'h0001);
    wait_resp(base + 3);
    check("t2_data", resp_data[base + 2], 32'hFFFF_8000);
    check("t2_err", 32'(resp_err[base + 2]), 32'd1);
    check("t2_halted", 32'(Halted), 32'd1);
    check("t2_cmdready", 32'(CmdReady), 32'd0);
    check("t2_sticky", 32'(ErrSticky), 32'd1);
    check("t2_done", 32'(DoneCount), 32'd6);
    pulse_clear();
    check("t2_clr_halted", 32'(Halted), 32'd0);
    check("t2_clr_sticky", 32'(ErrSticky), 32'd0);

    // Divide by zero halts with a command still queued; Clear flushes it.
    base = resp_data.size();
    send(4'b0001, 16'd0);
    send(4'b0111, 16'd5);
    send(4'b0100, 16'd1);
    wait_resp(base + 2);
    check("t3_err", 32'(resp_err[base + 1]), 32'd2);
    check("t3_halted", 32'(Halted), 32'd1);
    check("t3_sticky", 32'(ErrSticky), 32'd2);
    idle(10);
    check("t3_busy_held", 32'(Busy), 32'd1);
    check("t3_no_issue", resp_data.size(), base + 2);
    pulse_clear();
    check("t3_busy_flushed", 32'(Busy), 32'd0);
    check("t3_resumed", 32'(Halted), 32'd0);
    idle(10);
    check("t3_no_resp", resp_data.size(), base + 2);

    // Illegal opcode: not driven, accumulator unchanged, err[2] set.
    base = resp_data.size();
    send(4'b0001, 16'd0);
    send(4'b0100, 16'd250);
    send(4'b0011, 16'h1234);
    wait_resp(base + 3);
    check("t4_data", resp_data[base + 2], 32'h0000_00FA);
    check("t4_err", 32'(resp_err[base + 2]), 32'd4);
    check("t4_op", 32'(resp_op[base + 2]), 32'd3);
    check("t4_halted", 32'(Halted), 32'd1);
    pulse_clear();

    // Back-pressure: one in flight plus a full FIFO.
    base = resp_data.size();
    ResReady = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      CmdValid = 1'b1;
      CmdOp    = (accepted == 0) ? 4'b0001 : 4'b0100;
      CmdData  = 16'(accepted);
      @(negedge Clk);
      if (CmdReady) accepted++;
      @(posedge Clk);
      #1;
    end
    CmdValid = 1'b0;
    check("t5_accepted", accepted, 5);
    check("t5_cmdready", 32'(CmdReady), 32'd0);
    idle(6);
    check("t5_held_valid", 32'(ResValid), 32'd1);
    check("t5_none_consumed", resp_data.size(), base);
    ResReady = 1'b1;
    wait_resp(base + 5);
    check("t5_d0", resp_data[base], 32'd0);
    check("t5_d1", resp_data[base + 1], 32'd1);
    check("t5_d2", resp_data[base + 2], 32'd3);
    check("t5_d3", resp_data[base + 3], 32'd6);
    check("t5_d4", resp_data[base + 4], 32'd10);

    // Reset during CAPTURE abandons the command.
    base = resp_data.size();
    send(4'b0001, 16'd0);
    wait_resp(base + 1);
    send(4'b0100, 16'd5);
    @(posedge Clk);
    #1;
    check("t6_issue_op", 32'(DpOpCode), 32'd4);
    check("t6_issue_a", 32'(DpInputA), 32'd5);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("t6_resvalid", 32'(ResValid), 32'd0);
    check("t6_busy", 32'(Busy), 32'd0);
    check("t6_dpop", 32'(DpOpCode), 32'd0);
    check("t6_done", 32'(DoneCount), 32'd0);
    idle(10);
    check("t6_no_stale", resp_data.size(), base + 1);
    check("t6_still_idle", 32'(ResValid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
